int_fp_mul_arbiter: RTL

Round-robin arbiter sharing one `int_fp_mul` datapath between `N_REQ` requesters, each with a valid/ready operand port and a tagged response pulse. It issues one operation per cycle and tracks the multiplier pipeline with a tag shift register. It also sequences INT/FP mode changes: `mul_mode` never changes while an operation is in flight. The block sits between the requesting engines and the single multiplier instance.

---
 rtl/int_fp_mul_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/int_fp_mul_arbiter.sv
// Round-robin arbiter sharing one INT16/FP16 multiplier between N_REQ requesters.
// Tracks in-flight ops with a tag pipe and only switches mul_mode once the pipe has drained.
module int_fp_mul_arbiter #(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 16,
    parameter int MUL_LAT = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ*WIDTH-1:0]   req_a,
    input  logic [N_REQ*WIDTH-1:0]   req_b,
    input  logic [N_REQ-1:0]         req_mode,
    output logic [WIDTH-1:0]         mul_a,
    output logic [WIDTH-1:0]         mul_b,
    output logic                     mul_mode,
    input  logic [WIDTH-1:0]         mul_result,
    input  logic                     mul_underflow,
    input  logic                     mul_overflow,
    output logic [N_REQ-1:0]         rsp_valid,
    output logic [WIDTH-1:0]         rsp_result,
    output logic                     rsp_underflow,
    output logic                     rsp_overflow,
    output logic                     busy,
    output logic                     dbg_state
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int DEPTH = MUL_LAT + 1;
    localparam int IF_W  = $clog2(MUL_LAT + 2);

    typedef enum logic {
        ST_ISSUE = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t            state;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   lock_id;
    logic              cur_mode;
    logic [IF_W-1:0]   inflight;
    logic              tag_v  [DEPTH];
    logic [ID_W-1:0]   tag_id [DEPTH];

    logic              cand_found;
    logic [ID_W-1:0]   cand_id;
    logic [ID_W-1:0]   sel_id;
    logic              fire;
    logic              go_drain;
    logic              resp;
    logic [ID_W-1:0]   resp_id;
    logic              drained;

    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= N_REQ) s = s - N_REQ;
        return ID_W'(s);
    endfunction

    // Lowest index at or after rr_ptr wins; scanning downward lets the nearest one overwrite.
    always_comb begin
        cand_found = 1'b0;
        cand_id    = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_valid[wrap_add(rr_ptr, k)]) begin
                cand_found = 1'b1;
                cand_id    = wrap_add(rr_ptr, k);
            end
        end
    end

    assign resp    = tag_v[MUL_LAT];
    assign resp_id = tag_id[MUL_LAT];
    // An op retiring this cycle has already left the multiplier inputs, so it does not block a mode change.
    assign drained = (inflight == IF_W'(resp));
    assign sel_id  = (state == ST_DRAIN) ? lock_id : cand_id;

    // Handshake: a requester raises req_valid and holds it with stable operands/mode until it sees
    // req_ready in the same cycle; that cycle is the fire. req_ready never depends on rsp_* and is
    // one-hot or zero.
    always_comb begin
        fire     = 1'b0;
        go_drain = 1'b0;
        if (!reset) begin
            if (state == ST_DRAIN) begin
                fire = drained & req_valid[lock_id];
            end else if (cand_found) begin
                if ((req_mode[cand_id] == cur_mode) || drained) fire = 1'b1;
                else                                            go_drain = 1'b1;
            end
        end
    end

    assign req_ready     = fire ? (N_REQ'(1) << sel_id) : '0;
    assign rsp_valid     = resp ? (N_REQ'(1) << resp_id) : '0;
    assign rsp_result    = resp ? mul_result : '0;
    assign rsp_underflow = resp & mul_underflow;
    assign rsp_overflow  = resp & mul_overflow;
    assign busy          = (inflight != '0) || (state == ST_DRAIN);
    assign mul_mode      = cur_mode;
    assign dbg_state     = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_ISSUE;
            rr_ptr   <= '0;
            lock_id  <= '0;
            cur_mode <= 1'b0;
            mul_a    <= '0;
            mul_b    <= '0;
            inflight <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                tag_v[k]  <= 1'b0;
                tag_id[k] <= '0;
            end
        end else begin
            tag_v[0]  <= fire;
            tag_id[0] <= sel_id;
            for (int k = 1; k < DEPTH; k++) begin
                tag_v[k]  <= tag_v[k-1];
                tag_id[k] <= tag_id[k-1];
            end
            inflight <= inflight + IF_W'(fire) - IF_W'(resp);
            if (fire) begin
                mul_a    <= req_a[int'(sel_id)*WIDTH +: WIDTH];
                mul_b    <= req_b[int'(sel_id)*WIDTH +: WIDTH];
                cur_mode <= req_mode[sel_id];
                rr_ptr   <= wrap_add(sel_id, 1);
                state    <= ST_ISSUE;
            end else if (go_drain) begin
                lock_id  <= cand_id;
                state    <= ST_DRAIN;
            end
        end
    end

endmodule
